// File: rtl/iram_loader_pkg.sv
// iram_loader_pkg: loader FSM encodings and IRAM geometry shared with the IRAM and PC register
package iram_loader_pkg;
   localparam int IRAM_ADDR_W = 8;
   localparam int IRAM_DATA_W = 8;
   localparam int IRAM_DEPTH  = 1 << IRAM_ADDR_W;
   typedef enum logic [2:0] {
      LDR_IDLE,
      LDR_LEN,
      LDR_DATA,
      LDR_VERIFY,
      LDR_DONE
   } ldr_state_e;
endpackage

// File: rtl/iram_loader_addr_ctr.sv
// ldr_addr_ctr: byte index and wrapped IRAM address, shared by the write and verify passes
module ldr_addr_ctr import iram_loader_pkg::*; #(
   parameter int                ADDR_W    = IRAM_ADDR_W,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              clr_i,
   input  logic              inc_i,
   output logic [ADDR_W:0]   idx_o,
   output logic [ADDR_W-1:0] addr_o
);
   logic [ADDR_W:0] idx_q;
   // clear starts a new pass; increment on each accepted byte or issued read
   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) idx_q <= '0;
      else if (clr_i) idx_q <= '0;
      else if (inc_i) idx_q <= idx_q + 1'b1;
   assign idx_o  = idx_q;
   assign addr_o = BASE_ADDR + idx_q[ADDR_W-1:0];
endmodule

// File: rtl/iram_loader.sv
// iram_loader: fills IRAM from a length-prefixed byte stream and holds the CPU in reset meanwhile
// Optional read-back checksum pass enabled by defining IRAM_LOADER_VERIFY_EN.
module iram_loader import iram_loader_pkg::*; #(
   parameter int                ADDR_W    = IRAM_ADDR_W,
   parameter int                DATA_W    = IRAM_DATA_W,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              start_i,
   input  logic [DATA_W-1:0] in_data_i,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   output logic [ADDR_W-1:0] ram_addr_o,
   output logic [DATA_W-1:0] ram_data_o,
   output logic              ram_wren_o,
   input  logic [DATA_W-1:0] ram_q_i,
   output logic              cpu_hold_o,
   output logic              busy_o,
   output logic              done_o,
   output logic              err_o,
   output logic [ADDR_W:0]   count_o
);
   ldr_state_e        state_q;
   logic [ADDR_W:0]   len_q, len_d, count_q, idx;
   logic [ADDR_W-1:0] len_b, ctr_addr, ram_addr_q;
   logic [DATA_W-1:0] sum_q, sum_d, ram_data_q;
   logic              ram_wren_q, cpu_hold_q, busy_q, done_q, err_q;
   logic              xfer, go, last, clr, inc;

   assign in_ready_o = state_q == LDR_LEN || state_q == LDR_DATA;
   assign xfer       = in_valid_i && in_ready_o;
   assign go         = start_i && (state_q == LDR_IDLE || state_q == LDR_DONE);
   assign last       = state_q == LDR_DATA && xfer && idx + 1'b1 == len_q;
   assign len_b      = ADDR_W'(in_data_i);
   assign len_d      = {~|len_b, len_b};
   assign sum_d      = sum_q + in_data_i;

`ifdef IRAM_LOADER_VERIFY_EN
   localparam ldr_state_e AFTER_DATA = LDR_VERIFY;
   logic              rd_q, rd_more;
   logic [DATA_W-1:0] vsum_q, vsum_d;
   assign rd_more = idx != len_q;
   assign vsum_d  = vsum_q + ram_q_i;
   assign clr     = go || last;
   assign inc     = (state_q == LDR_DATA && xfer) || (state_q == LDR_VERIFY && rd_more);
`else
   localparam ldr_state_e AFTER_DATA = LDR_DONE;
   logic unused_ram_q;
   assign unused_ram_q = ^ram_q_i;
   assign clr          = go;
   assign inc          = state_q == LDR_DATA && xfer;
`endif

   ldr_addr_ctr #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR)) u_ctr (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .clr_i  (clr),
      .inc_i  (inc),
      .idx_o  (idx),
      .addr_o (ctr_addr)
   );

   // loader FSM with registered IRAM write port and status outputs
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= LDR_IDLE;
         len_q      <= '0;
         count_q    <= '0;
         sum_q      <= '0;
         ram_addr_q <= '0;
         ram_data_q <= '0;
         ram_wren_q <= 1'b0;
         cpu_hold_q <= 1'b1;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
`ifdef IRAM_LOADER_VERIFY_EN
         rd_q       <= 1'b0;
         vsum_q     <= '0;
`endif
      end else begin
         ram_wren_q <= 1'b0;
         case (state_q)
            LDR_LEN: if (in_valid_i) begin
               len_q   <= len_d;
               state_q <= LDR_DATA;
            end
            LDR_DATA: begin
               if (in_valid_i) begin
                  ram_wren_q <= 1'b1;
                  ram_addr_q <= ctr_addr;
                  ram_data_q <= in_data_i;
                  count_q    <= count_q + 1'b1;
                  sum_q      <= sum_d;
                  if (last) state_q <= AFTER_DATA;
               end
`ifdef IRAM_LOADER_VERIFY_EN
               rd_q   <= 1'b0;
               vsum_q <= '0;
`endif
            end
`ifdef IRAM_LOADER_VERIFY_EN
            // read back one address per cycle; ram_q arrives a cycle after its address
            LDR_VERIFY: begin
               rd_q <= rd_more;
               if (rd_more) ram_addr_q <= ctr_addr;
               if (rd_q) vsum_q <= vsum_d;
               if (rd_q && !rd_more) begin
                  err_q   <= vsum_d != sum_q;
                  state_q <= LDR_DONE;
               end
            end
`endif
            LDR_DONE: begin
               busy_q     <= 1'b0;
               done_q     <= 1'b1;
               cpu_hold_q <= err_q;
            end
            default: state_q <= LDR_IDLE;
         endcase
         if (go) begin
            state_q    <= LDR_LEN;
            busy_q     <= 1'b1;
            cpu_hold_q <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            count_q    <= '0;
            sum_q      <= '0;
         end
      end
   end

   assign ram_addr_o = ram_addr_q;
   assign ram_data_o = ram_data_q;
   assign ram_wren_o = ram_wren_q;
   assign cpu_hold_o = cpu_hold_q;
   assign busy_o     = busy_q;
   assign done_o     = done_q;
   assign err_o      = err_q;
   assign count_o    = count_q;
endmodule

// File: doc/iram_loader.md
Name: iram_loader

Overview:
- Writer side of the instruction RAM. The CPU fetch path only reads IRAM (PC to address, q to IR); this block fills it.
- Accepts a length-prefixed byte stream over a valid/ready handshake, fed by a switch-entry or serial receiver front end.
- Writes the bytes into IRAM at consecutive addresses from BASE_ADDR.
- Holds the processor in reset while loading. On completion, releases the processor with the PC starting from a freshly loaded program.

Parameters:
- ADDR_W, 8, IRAM address width; a program holds at most 2^ADDR_W bytes.
- DATA_W, 8, IRAM word width and stream byte width.
- BASE_ADDR, 0, first IRAM address written.

Ports:
- clk  in  1  system clock; the same divided clock that drives the Control Unit and IRAM.
- rst  in  1  reset, asynchronous, active-low.
- start  in  1  single-cycle request to begin a load; sampled only in IDLE.
- in_data  in  DATA_W  stream byte.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  loader can accept a byte; a transfer happens when in_valid && in_ready.
- ram_addr  out  ADDR_W  IRAM address.
- ram_data  out  DATA_W  IRAM write data.
- ram_wren  out  1  IRAM write enable.
- ram_q  in  DATA_W  IRAM read data; 1-cycle latency after ram_addr (used only with VERIFY_EN).
- cpu_hold  out  1  drives PC/CU reset while high.
- busy  out  1  load in progress.
- done  out  1  last load finished; held high until the next start.
- err  out  1  verify mismatch on the last load.
- count  out  ADDR_W+1  bytes written in the current or last load.

Behaviour:
- Reset (rst=0, asynchronous):
  - FSM goes to IDLE.
  - All outputs are 0 except cpu_hold=1, so the CPU stays held until the first successful load.
  - Internal length, address and checksum registers are cleared.
- All outputs are registered, except in_ready, which is a decode of the state.
- FSM states: IDLE, LEN, DATA, VERIFY (VERIFY_EN only), DONE.
- IDLE:
  - in_ready=0.
  - start=1 goes to LEN; sets busy=1 and cpu_hold=1, clears done, err and count.
- LEN:
  - in_ready=1.
  - The accepted byte is latched as length N. N=0 means 2^ADDR_W bytes.
  - Next state is DATA.
- DATA:
  - in_ready=1.
  - Byte accepted at cycle t gives ram_wren=1, ram_addr=BASE_ADDR+idx and ram_data=byte at cycle t+1.
  - idx increments, count increments, and the byte is added to the checksum (sum mod 2^DATA_W).
  - ram_wren=0 on any cycle with no transfer.
  - Gaps in in_valid stall the load with no writes.
  - Address wraps modulo 2^ADDR_W (BASE_ADDR+idx overflow wraps to 0).
  - After the Nth byte is accepted, in_ready drops the next cycle. Next state is VERIFY or DONE.
- DONE:
  - busy=0, done=1, cpu_hold=0.
  - start goes back to LEN as above, giving a reload.
- start while busy: ignored.
- in_valid outside LEN/DATA: ignored, with in_ready=0.
- Reset mid-load: the load is abandoned. Partially written IRAM contents stay, cpu_hold=1, and a fresh start is required.
- The final write and the busy=0 transition never occur in the same cycle.
  - The last ram_wren pulse is in the cycle DONE (or VERIFY) is entered.
  - done rises one cycle later.

Optional Feature:
- Macro: IRAM_LOADER_VERIFY_EN.
- With the macro:
  - After DATA, the loader enters VERIFY with ram_wren=0.
  - It reads addresses BASE_ADDR..BASE_ADDR+N-1 one per cycle and sums ram_q with 1-cycle latency.
  - After the last read data returns, it compares the sum with the load checksum.
  - err=1 on mismatch. DONE is still entered, but cpu_hold stays 1 when err=1.
  - VERIFY takes N+1 cycles.
- Without the macro:
  - There is no VERIFY state and no ram_q logic; err is tied to 0.
  - DATA goes directly to DONE.

Decomposition:
- Shared package/define file holds:
  - the FSM state encodings (LDR_IDLE, LDR_LEN, LDR_DATA, LDR_VERIFY, LDR_DONE);
  - IRAM depth/width constants shared with the IRAM and PC register instantiation.
- One natural sub-module, ldr_addr_ctr. It is the idx/address/count counter with clear, increment and wrap, and it is reused by the write and verify passes.

Test Plan:
- Reset, then start; stream 03, A1, B2, C3 with in_valid constant → writes (0,A1), (1,B2), (2,C3) on consecutive cycles; count=3; checksum 0x16; done=1 and cpu_hold=0 one cycle after the last write.
- Same stream with in_valid low for 2 cycles between each byte → no ram_wren during gaps; same addresses and data; in_ready stays 1 in DATA.
- Length byte 00 with 256 bytes of value i → 256 writes at addresses 0..FF; count=256; no write beyond FF.
- BASE_ADDR=F0, length 20 → address wraps from FF to 00 and ends at 0F.
- rst low after 2 of 5 data bytes → immediate IDLE with cpu_hold=1 and busy=0; a new start with length 01 then 5A writes (0,5A).
- With IRAM_LOADER_VERIFY_EN, ram model corrupting address 1 → err=1, done=1, cpu_hold=1; with a clean model → err=0, cpu_hold=0.
- start pulsed during DATA → ignored; load completes normally.
